mod_updown_counter: RTL and testbench

// - Parametrised synchronous loadable modulo up/down counter spanning [MIN_VAL..MAX_VAL].
// - Generalises the fixed 4-bit 2..10 counter with configurable width and bounds, a count enable,
//   and run-time boundary modes (wrap / saturate / ping-pong). Adds boundary and event flags.
// - Drop-in for the same count_if-style interface, which gains en, mode and the status outputs.

---
 rtl/mod_cnt_pkg.sv | 16 +
 rtl/mod_cnt_next.sv | 92 +++++++++
 rtl/mod_updown_counter.sv | 107 ++++++++++
 tb/tb_mod_updown_counter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_cnt_pkg.sv
// Shared types for the loadable modulo up/down counter: boundary modes and count direction.
package mod_cnt_pkg;

    typedef enum logic [1:0] {
        WRAP     = 2'd0,
        SAT      = 2'd1,
        PINGPONG = 2'd2,
        HOLD     = 2'd3
    } cnt_mode_e;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } cnt_dir_e;

endpackage

// File: rtl/mod_cnt_next.sv
// Combinational next-state for one enabled counting step: wrap, saturate, ping-pong or hold.
module mod_cnt_next
    import mod_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 2,
    parameter int MAX_VAL = 10
) (
    input  logic [WIDTH-1:0] count,
    input  cnt_dir_e         dir,
    input  cnt_mode_e        mode,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count,
    output cnt_dir_e         next_dir,
    output logic             boundary_event
);

    localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);

    // One spare bit keeps MAX+1 / MIN-1 comparable without wrapping the register width.
    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] inc_x;
    logic [WIDTH:0] dec_x;

    assign cnt_x = {1'b0, count};
    assign inc_x = cnt_x + (WIDTH+1)'(1);
    assign dec_x = cnt_x - (WIDTH+1)'(1);

    always_comb begin
        next_count     = count;
        next_dir       = dir;
        boundary_event = 1'b0;
        case (mode)
            WRAP, SAT: begin
                next_dir = up_down ? DIR_UP : DIR_DN;
                if (up_down) begin
                    if (cnt_x >= MAX_X) begin
                        if (mode == WRAP) begin
                            next_count     = MIN_X[WIDTH-1:0];
                            boundary_event = 1'b1;
                        end
                    end else begin
                        next_count     = inc_x[WIDTH-1:0];
                        boundary_event = (mode == SAT) && (inc_x == MAX_X);
                    end
                end else begin
                    if (cnt_x <= MIN_X) begin
                        if (mode == WRAP) begin
                            next_count     = MAX_X[WIDTH-1:0];
                            boundary_event = 1'b1;
                        end
                    end else begin
                        next_count     = dec_x[WIDTH-1:0];
                        boundary_event = (mode == SAT) && (dec_x == MIN_X);
                    end
                end
            end
            PINGPONG: begin
                // A direction that points past a bound (e.g. after a load onto it) bounces immediately.
                if (dir == DIR_UP) begin
                    if (cnt_x >= MAX_X) begin
                        next_count     = dec_x[WIDTH-1:0];
                        next_dir       = (dec_x == MIN_X) ? DIR_UP : DIR_DN;
                        boundary_event = 1'b1;
                    end else begin
                        next_count = inc_x[WIDTH-1:0];
                        if (inc_x == MAX_X) begin
                            next_dir       = DIR_DN;
                            boundary_event = 1'b1;
                        end
                    end
                end else begin
                    if (cnt_x <= MIN_X) begin
                        next_count     = inc_x[WIDTH-1:0];
                        next_dir       = (inc_x == MAX_X) ? DIR_DN : DIR_UP;
                        boundary_event = 1'b1;
                    end else begin
                        next_count = dec_x[WIDTH-1:0];
                        if (dec_x == MIN_X) begin
                            next_dir       = DIR_UP;
                            boundary_event = 1'b1;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Loadable modulo up/down counter over [MIN_VAL..MAX_VAL] with run-time boundary modes and status flags.
module mod_updown_counter
    import mod_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 2,
    parameter int MAX_VAL = 10
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up_down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             at_max,
    output logic             at_min,
    output logic             event_p,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    generate
        if (WIDTH < 2 || WIDTH > 32 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
            64'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_params
            $error("mod_updown_counter: need 2<=WIDTH<=32 and 0<=MIN_VAL<MAX_VAL<2**WIDTH");
        end
    endgenerate

    cnt_mode_e        mode_e;
    logic [WIDTH-1:0] count_q, count_d;
    cnt_dir_e         dir_q, dir_d;
    logic             event_q, event_d;
    logic             lerr_q, lerr_d;

    logic [WIDTH-1:0] step_count;
    cnt_dir_e         step_dir;
    logic             step_event;

    assign mode_e = cnt_mode_e'(mode);

    mod_cnt_next #(
        .WIDTH  (WIDTH),
        .MIN_VAL(MIN_VAL),
        .MAX_VAL(MAX_VAL)
    ) u_next (
        .count         (count_q),
        .dir           (dir_q),
        .mode          (mode_e),
        .up_down       (up_down),
        .next_count    (step_count),
        .next_dir      (step_dir),
        .boundary_event(step_event)
    );

    // Load beats enable; a disabled edge holds state and drops both pulses.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        event_d = 1'b0;
        lerr_d  = 1'b0;
        if (!load) begin
            if (din < MIN_W) begin
                count_d = MIN_W;
                lerr_d  = 1'b1;
            end else if (din > MAX_W) begin
                count_d = MAX_W;
                lerr_d  = 1'b1;
            end else begin
                count_d = din;
            end
            if (mode_e == WRAP || mode_e == SAT) begin
                dir_d = up_down ? DIR_UP : DIR_DN;
            end
        end else if (en) begin
            count_d = step_count;
            dir_d   = step_dir;
            event_d = step_event;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= MIN_W;
            dir_q   <= DIR_UP;
            event_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            event_q <= event_d;
            lerr_q  <= lerr_d;
        end
    end

    assign count    = count_q;
    assign dir      = (dir_q == DIR_UP);
    assign at_max   = (count_q == MAX_W);
    assign at_min   = (count_q == MIN_W);
    assign event_p  = event_q;
    assign load_err = lerr_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a behavioural model checked every cycle plus literal expectations.
module tb_mod_updown_counter;

    localparam int W    = 4;
    localparam int MINV = 2;
    localparam int MAXV = 10;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         load = 1'b1;
    logic [W-1:0] din = '0;
    logic         en = 1'b0;
    logic         up_down = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] count;
    logic         dir, at_max, at_min, event_p, load_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int m_count = MINV;
    int m_dir   = 1;
    int m_ev    = 0;
    int m_lerr  = 0;

    mod_updown_counter #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .load    (load),
        .din     (din),
        .en      (en),
        .up_down (up_down),
        .mode    (mode),
        .count   (count),
        .dir     (dir),
        .at_max  (at_max),
        .at_min  (at_min),
        .event_p (event_p),
        .load_err(load_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < MINV) return MINV;
        if (v > MAXV) return MAXV;
        return v;
    endfunction

    // Reference model: the counting rules expressed directly on integers.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_count <= MINV;
            m_dir   <= 1;
            m_ev    <= 0;
            m_lerr  <= 0;
        end else if (!load) begin
            m_count <= clampv(int'(din));
            m_lerr  <= (int'(din) < MINV || int'(din) > MAXV) ? 1 : 0;
            m_ev    <= 0;
            if (mode == 2'd0 || mode == 2'd1) m_dir <= int'(up_down);
        end else if (!en || mode == 2'd3) begin
            m_ev   <= 0;
            m_lerr <= 0;
        end else begin
            m_lerr <= 0;
            case (mode)
                2'd0: begin
                    m_dir <= int'(up_down);
                    if (up_down) begin
                        m_count <= (m_count == MAXV) ? MINV : m_count + 1;
                        m_ev    <= (m_count == MAXV) ? 1 : 0;
                    end else begin
                        m_count <= (m_count == MINV) ? MAXV : m_count - 1;
                        m_ev    <= (m_count == MINV) ? 1 : 0;
                    end
                end
                2'd1: begin
                    m_dir <= int'(up_down);
                    if (up_down) begin
                        m_count <= (m_count < MAXV) ? m_count + 1 : MAXV;
                        m_ev    <= (m_count + 1 == MAXV) ? 1 : 0;
                    end else begin
                        m_count <= (m_count > MINV) ? m_count - 1 : MINV;
                        m_ev    <= (m_count - 1 == MINV) ? 1 : 0;
                    end
                end
                default: begin
                    if (m_dir == 1) begin
                        m_count <= m_count + 1;
                        m_ev    <= (m_count + 1 == MAXV) ? 1 : 0;
                        if (m_count + 1 == MAXV) m_dir <= 0;
                    end else begin
                        m_count <= m_count - 1;
                        m_ev    <= (m_count - 1 == MINV) ? 1 : 0;
                        if (m_count - 1 == MINV) m_dir <= 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_count", int'(count), m_count);
            chk("model_dir", int'(dir), m_dir);
            chk("model_at_max", int'(at_max), (m_count == MAXV) ? 1 : 0);
            chk("model_at_min", int'(at_min), (m_count == MINV) ? 1 : 0);
            chk("model_event_p", int'(event_p), m_ev);
            chk("model_load_err", int'(load_err), m_lerr);
        end
    end

    task automatic tick(input logic ld, input int d, input logic e, input logic ud, input logic [1:0] md);
        load    = ld;
        din     = W'(d);
        en      = e;
        up_down = ud;
        mode    = md;
        @(posedge clock);
        #1;
        $display("[TB] load=%0b din=%0d en=%0b ud=%0b mode=%0d -> count=%0d dir=%0b ev=%0b lerr=%0b",
                 ld, d, e, ud, md, count, dir, event_p, load_err);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    int evs;

    initial begin
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", int'(count), 2);
        chk("rst_dir", int'(dir), 1);
        chk("rst_event", int'(event_p), 0);
        chk("rst_lerr", int'(load_err), 0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // Asynchronous reset mid-count, away from any clock edge
        tick(1'b0, 7, 1'b0, 1'b1, 2'd0);
        chk("load7", int'(count), 7);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 2);
        chk("async_rst_dir", int'(dir), 1);
        chk("async_rst_event", int'(event_p), 0);
        chk("async_rst_lerr", int'(load_err), 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        tick(1'b1, 0, 1'b1, 1'b1, 2'd0);
        chk("post_rst_first", int'(count), 3);

        // WRAP
        tick(1'b0, 9, 1'b0, 1'b1, 2'd0);
        tick(1'b1, 0, 1'b1, 1'b1, 2'd0);
        chk("wrap_up_10", int'(count), 10);
        tick(1'b1, 0, 1'b1, 1'b1, 2'd0);
        chk("wrap_up_2", int'(count), 2);
        chk("wrap_up_ev", int'(event_p), 1);
        tick(1'b1, 0, 1'b1, 1'b1, 2'd0);
        chk("wrap_up_3", int'(count), 3);
        chk("wrap_up_3_ev", int'(event_p), 0);
        tick(1'b0, 2, 1'b0, 1'b0, 2'd0);
        tick(1'b1, 0, 1'b1, 1'b0, 2'd0);
        chk("wrap_dn_10", int'(count), 10);
        chk("wrap_dn_ev", int'(event_p), 1);
        chk("wrap_dn_dir", int'(dir), 0);

        // SAT
        tick(1'b0, 9, 1'b0, 1'b1, 2'd1);
        tick(1'b1, 0, 1'b1, 1'b1, 2'd1);
        chk("sat_up_10a", int'(count), 10);
        chk("sat_up_ev_a", int'(event_p), 1);
        tick(1'b1, 0, 1'b1, 1'b1, 2'd1);
        chk("sat_up_10b", int'(count), 10);
        chk("sat_up_ev_b", int'(event_p), 0);
        tick(1'b1, 0, 1'b1, 1'b1, 2'd1);
        chk("sat_up_10c", int'(count), 10);
        tick(1'b0, 3, 1'b0, 1'b0, 2'd1);
        tick(1'b1, 0, 1'b1, 1'b0, 2'd1);
        chk("sat_dn_2a", int'(count), 2);
        chk("sat_dn_ev_a", int'(event_p), 1);
        tick(1'b1, 0, 1'b1, 1'b0, 2'd1);
        chk("sat_dn_2b", int'(count), 2);
        chk("sat_dn_ev_b", int'(event_p), 0);

        // PINGPONG from reset, up_down toggled randomly
        do_reset();
        evs = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 0, 1'b1, 1'($urandom_range(0, 1)), 2'd2);
            evs += int'(event_p);
            if (i == 7) chk("pp_top", int'(count), 10);
            if (i == 7) chk("pp_top_dir", int'(dir), 0);
            if (i == 15) chk("pp_bottom", int'(count), 2);
            if (i == 15) chk("pp_bottom_dir", int'(dir), 1);
        end
        chk("pp_final", int'(count), 6);
        chk("pp_events", evs, 2);

        // Load clamp and priority over enable
        tick(1'b0, 14, 1'b1, 1'b1, 2'd0);
        chk("clamp_hi", int'(count), 10);
        chk("clamp_hi_err", int'(load_err), 1);
        tick(1'b0, 0, 1'b1, 1'b1, 2'd0);
        chk("clamp_lo", int'(count), 2);
        chk("clamp_lo_err", int'(load_err), 1);
        tick(1'b0, 5, 1'b1, 1'b1, 2'd0);
        chk("load_in_range", int'(count), 5);
        chk("load_in_range_err", int'(load_err), 0);

        // Hold with en = 0, then mode 3 with en = 1
        tick(1'b0, 6, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 0, 1'b0, 1'b1, 2'd0);
            chk("hold_en0", int'(count), 6);
            chk("hold_en0_ev", int'(event_p), 0);
        end
        tick(1'b1, 0, 1'b1, 1'b1, 2'd3);
        chk("hold_mode3", int'(count), 6);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
